// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side packing logic: packer FSM encoding and
// the width helper used for lane counts.
package fifo_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bits needed to hold any value 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pulls narrow entries from a FIFO read port and packs PACK_RATIO of them into
// one wide word offered on a valid/ready output. A flush pulse releases a
// partially filled word; unused lanes of a partial word read as zero.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 4,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]                fifo_rd_data,
  input  logic                                 fifo_rd_val,
  input  logic                                 flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0]     out_data,
  output logic [count_width(PACK_RATIO)-1:0]   out_count,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int CW = count_width(PACK_RATIO);
  localparam int OW = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] FULL  = CW'(PACK_RATIO);
  localparam logic [CW:0]   LIMIT = (CW+1)'(PACK_RATIO);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pending;
  logic          flush_req, flush_req_nxt;
  logic          run;
  logic [OW-1:0] data_nxt;
  logic [CW-1:0] count_nxt;
  logic          valid_nxt;
  logic          capture;
  logic [CW:0]   outstanding;

  // Write one entry into the lane selected by the capture index.
  function automatic logic [OW-1:0] place_lane(input logic [OW-1:0]         word,
                                               input logic [CW-1:0]         idx,
                                               input logic [DATA_WIDTH-1:0] d);
    logic [OW-1:0] w;
    int            lane;
    w    = word;
    lane = LSB_FIRST ? int'(idx) : (PACK_RATIO - 1 - int'(idx));
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (i == lane) w[i*DATA_WIDTH +: DATA_WIDTH] = d;
    end
    return w;
  endfunction

  // Read data is only meaningful in the cycle after a request; rd_val is
  // sticky in the FIFO and must be ignored otherwise.
  assign capture     = pending & fifo_rd_val;
  assign outstanding = {1'b0, cnt} + (CW+1)'(pending);
  // run keeps reads off while reset is held, without using reset combinationally.
  assign fifo_rd_en  = run & (state == FILL) & ~flush_req & (outstanding < LIMIT);

  // Next-state, lane capture and output-word decisions.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    flush_req_nxt = flush_req;
    data_nxt      = out_data;
    count_nxt     = out_count;
    valid_nxt     = out_valid;

    if (capture && state != HOLD) begin
      data_nxt = place_lane(out_data, cnt, fifo_rd_data);
      cnt_nxt  = cnt + CW'(1);
    end

    case (state)
      FILL: begin
        // A completing capture beats a simultaneous flush; the flush is dropped.
        if (capture && cnt_nxt == FULL) begin
          state_nxt = HOLD;
          valid_nxt = 1'b1;
          count_nxt = FULL;
        end else if (flush && (cnt != '0 || pending)) begin
          state_nxt     = DRAIN;
          flush_req_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (capture && cnt_nxt == FULL) begin
          state_nxt = HOLD;
          valid_nxt = 1'b1;
          count_nxt = FULL;
        end else if (!pending) begin
          if (cnt != '0) begin
            state_nxt = HOLD;
            valid_nxt = 1'b1;
            count_nxt = cnt;
          end else begin
            state_nxt     = FILL;
            flush_req_nxt = 1'b0;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt     = FILL;
          valid_nxt     = 1'b0;
          cnt_nxt       = '0;
          flush_req_nxt = 1'b0;
          data_nxt      = '0;
          count_nxt     = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      cnt       <= '0;
      pending   <= 1'b0;
      flush_req <= 1'b0;
      run       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pending   <= fifo_rd_en;
      flush_req <= flush_req_nxt;
      run       <= 1'b1;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// FIFO model feeding two packers (LSB-first and MSB-first) in lock step; a
// scoreboard queue holds expected words and a negedge monitor checks them.
module tb_fifo_word_packer;
  import fifo_pkg::*;

  localparam int DW = 4;
  localparam int PR = 4;
  localparam int CW = count_width(PR);
  localparam int OW = DW * PR;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic          rd_en_a, rd_en_b;
  logic [DW-1:0] rd_data = '0;
  logic          rd_val = 1'b0;
  logic [OW-1:0] data_a, data_b;
  logic [CW-1:0] count_a, count_b;
  logic          valid_a, valid_b;

  typedef struct packed {
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data),
    .fifo_rd_val(rd_val), .flush(flush), .out_data(data_a), .out_count(count_a),
    .out_valid(valid_a), .out_ready(out_ready)
  );

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data),
    .fifo_rd_val(rd_val), .flush(flush), .out_data(data_b), .out_count(count_b),
    .out_valid(valid_b), .out_ready(out_ready)
  );

  // FIFO read port: registered data, rd_val sticky between reads.
  always @(posedge clk) begin
    if (!reset) begin
      rd_val  <= 1'b0;
      rd_data <= '0;
    end else if (rd_en_a) begin
      if (fifo_q.size() > 0) begin
        rd_data <= fifo_q.pop_front();
        rd_val  <= 1'b1;
      end else begin
        rd_val  <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [OW-1:0] a, input logic [OW-1:0] b, input int c);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.cnt = CW'(c);
    exp_q.push_back(e);
  endtask

  task automatic push4(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                       input logic [DW-1:0] v2, input logic [DW-1:0] v3);
    fifo_q.push_back(v0);
    fifo_q.push_back(v1);
    fifo_q.push_back(v2);
    fifo_q.push_back(v3);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drained(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      tick(1);
      k++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=%0d required=0 words pending", name, exp_q.size());
      exp_q.delete();
    end
    tick(1);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && valid_a && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word actual=%0h required=none", data_a);
      end else begin
        e = exp_q.pop_front();
        check("word_lsb_first", 32'(data_a), 32'(e.a));
        check("word_msb_first", 32'(data_b), 32'(e.b));
        check("count_lsb_first", 32'(count_a), 32'(e.cnt));
        check("count_msb_first", 32'(count_b), 32'(e.cnt));
        check("valid_msb_first", 32'(valid_b), 32'd1);
      end
    end
  end

  initial begin
    int got;

    // Reset state
    tick(3);
    @(negedge clk);
    check("reset_rd_en", 32'(rd_en_a), 32'd0);
    check("reset_valid", 32'(valid_a), 32'd0);
    check("reset_data", 32'(data_a), 32'd0);
    check("reset_count", 32'(count_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Full word, ready high: 7,6,5,4
    push4(4'h7, 4'h6, 4'h5, 4'h4);
    expect_word(16'h4567, 16'h7654, 4);
    wait_drained("full_word");
    @(negedge clk);
    check("valid_one_cycle", 32'(valid_a), 32'd0);
    tick(1);

    // Backpressure for five cycles, with a flush in HOLD that must be ignored
    out_ready = 1'b0;
    push4(4'hA, 4'hB, 4'hC, 4'hD);
    expect_word(16'hDCBA, 16'hABCD, 4);
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid_a) begin
        got = 1;
        break;
      end
    end
    check("bp_valid_seen", 32'(got), 32'd1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_data_stable", 32'(data_a), 32'hDCBA);
      check("bp_count_stable", 32'(count_a), 32'd4);
      check("bp_valid_held", 32'(valid_a), 32'd1);
      check("bp_no_read", 32'(rd_en_a), 32'd0);
      @(posedge clk);
      #1;
      flush     = (j == 1);
      out_ready = (j == 4);
    end
    flush = 1'b0;
    @(negedge clk);
    check("bp_accept_no_read", 32'(rd_en_a), 32'd0);
    @(negedge clk);
    check("bp_released_valid", 32'(valid_a), 32'd0);
    check("bp_first_new_read", 32'(rd_en_a), 32'd1);
    wait_drained("backpressure");

    // Empty FIFO: reads keep firing, all return rd_val=0
    tick(20);
    @(negedge clk);
    check("empty_valid", 32'(valid_a), 32'd0);
    check("empty_reads_issued", 32'(rd_en_a), 32'd1);
    @(posedge clk);
    #1;
    push4(4'h1, 4'h2, 4'h3, 4'h4);
    expect_word(16'h4321, 16'h1234, 4);
    wait_drained("after_empty");

    // Partial word via flush, then next word starts at lane 0
    fifo_q.push_back(4'h7);
    fifo_q.push_back(4'h6);
    tick(8);
    expect_word(16'h0067, 16'h7600, 2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_drained("flush_partial");
    push4(4'h8, 4'h9, 4'hA, 4'hB);
    expect_word(16'hBA98, 16'h89AB, 4);
    wait_drained("after_flush");

    // Reset mid-word discards captured lanes
    fifo_q.push_back(4'h5);
    fifo_q.push_back(4'h6);
    tick(6);
    reset = 1'b0;
    fifo_q.delete();
    tick(2);
    @(negedge clk);
    check("midreset_rd_en", 32'(rd_en_a), 32'd0);
    check("midreset_valid", 32'(valid_a), 32'd0);
    check("midreset_data", 32'(data_a), 32'd0);
    check("midreset_count", 32'(count_a), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push4(4'h1, 4'h2, 4'h3, 4'h4);
    expect_word(16'h4321, 16'h1234, 4);
    wait_drained("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
